// File: rtl/ifetch_lineq.sv
// Instruction fetch front end: prefetches 64-bit lines into a two-entry line
// queue and presents one aligned RV32/RVC instruction per cycle to decode.
module ifetch_lineq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    input  logic        lr_isram_cs,
    output logic        isram_cs,
    output logic [28:0] isram_addr,
    input  logic [63:0] isram_rdata,
    output logic        fe_valid,
    output logic [31:0] fe_pc,
    output logic [31:0] fe_instr,
    output logic        fe_isrv16
);

    localparam logic [2:0] QD = 3'(QDEPTH);

    logic [31:0] pc_q, pc_d;
    logic [28:0] req_line_q, req_line_d;
    logic [63:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic [28:0] lad0_q, lad0_d, lad1_q, lad1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        inflight_q, inflight_d;
    logic        kill_q, kill_d;
    logic [28:0] fly_line_q, fly_line_d;

    logic [1:0]  off;
    logic [31:0] ext;
    logic        need_hi;
    logic        consume;
    logic        pop;
    logic        push;
    logic [31:0] pc_step;
    logic [2:0]  occ;

    assign off     = pc_q[2:1];
    assign occ     = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign need_hi = (off == 2'd3) && (dat0_q[49:48] == 2'b11);

    // Pick the 32-bit window at the current halfword; offset 3 straddles into the second line.
    always_comb begin
        ext = dat0_q[31:0];
        case (off)
            2'd0:    ext = dat0_q[31:0];
            2'd1:    ext = dat0_q[47:16];
            2'd2:    ext = dat0_q[63:32];
            default: ext = {dat1_q[15:0], dat0_q[63:48]};
        endcase
    end

    // A straddling 32-bit instruction waits for its upper half; nothing is shown while redirecting.
    assign fe_valid  = !redirect && (cnt_q != 2'd0) && (!need_hi || cnt_q == 2'd2);
    assign fe_instr  = fe_valid ? ext : 32'h0;
    assign fe_isrv16 = fe_valid && (ext[1:0] != 2'b11);
    assign fe_pc     = pc_q;

    // Never let queued plus outstanding lines exceed the queue, so a response always has a slot.
    assign isram_cs   = rst_n && !lr_isram_cs && !redirect && (occ < QD);
    assign isram_addr = req_line_q;

    assign consume = fe_valid && dec_ready;
    assign pc_step = pc_q + (fe_isrv16 ? 32'd2 : 32'd4);
    assign pop     = consume && (pc_step[31:3] != lad0_q);
    assign push    = inflight_q && !kill_q && !redirect;

    // Next state: redirect flushes everything; otherwise consume/pop then append the returning line.
    always_comb begin
        pc_d       = pc_q;
        req_line_d = req_line_q;
        dat0_d     = dat0_q;
        dat1_d     = dat1_q;
        lad0_d     = lad0_q;
        lad1_d     = lad1_q;
        cnt_d      = cnt_q;
        inflight_d = isram_cs;
        kill_d     = 1'b0;
        fly_line_d = fly_line_q;
        if (isram_cs) begin
            req_line_d = req_line_q + 29'd1;
            fly_line_d = req_line_q;
        end
        if (redirect) begin
            pc_d       = redirect_pc & ~32'h1;
            req_line_d = redirect_pc[31:3];
            cnt_d      = 2'd0;
            kill_d     = inflight_q;
        end else begin
            if (consume) pc_d = pc_step;
            if (pop) begin
                dat0_d = dat1_q;
                lad0_d = lad1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            if (push) begin
                if (cnt_d == 2'd0) begin
                    dat0_d = isram_rdata;
                    lad0_d = fly_line_q;
                end else begin
                    dat1_d = isram_rdata;
                    lad1_d = fly_line_q;
                end
                cnt_d = cnt_d + 2'd1;
            end
        end
    end

    // State registers; reset drops all buffered and outstanding lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_line_q <= RESET_PC[31:3];
            dat0_q     <= 64'h0;
            dat1_q     <= 64'h0;
            lad0_q     <= 29'h0;
            lad1_q     <= 29'h0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            fly_line_q <= 29'h0;
        end else begin
            pc_q       <= pc_d;
            req_line_q <= req_line_d;
            dat0_q     <= dat0_d;
            dat1_q     <= dat1_d;
            lad0_q     <= lad0_d;
            lad1_q     <= lad1_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            fly_line_q <= fly_line_d;
        end
    end

endmodule
